// File: rtl/sync_nff_filter_if.sv
// rtl/sync_nff_filter_if.sv - level and edge signal bundle for sync_nff_filter
//
// Purpose: groups the per-channel source levels, the sticky clear and the
//          synchronised outputs of sync_nff_filter into one port.
// Signals:
//   src_signal      WIDTH  asynchronous input levels (driven by master)
//   sticky_clr      WIDTH  per-channel clear for dst_sticky_rise (dst_clk domain)
//   dst_signal      WIDTH  synchronised, filtered level
//   dst_rise        WIDTH  one-cycle pulse on dst_signal 0->1
//   dst_fall        WIDTH  one-cycle pulse on dst_signal 1->0
//   dst_change      1      OR of all rise and fall bits
//   dst_sticky_rise WIDTH  latched rise flags
// Modports: master drives the sources, slave is the synchroniser.

interface sync_nff_filter_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] src_signal;
   logic [WIDTH-1:0] sticky_clr;
   logic [WIDTH-1:0] dst_signal;
   logic [WIDTH-1:0] dst_rise;
   logic [WIDTH-1:0] dst_fall;
   logic             dst_change;
   logic [WIDTH-1:0] dst_sticky_rise;

   modport master (
      output src_signal,
      output sticky_clr,
      input  dst_signal,
      input  dst_rise,
      input  dst_fall,
      input  dst_change,
      input  dst_sticky_rise
   );

   modport slave (
      input  src_signal,
      input  sticky_clr,
      output dst_signal,
      output dst_rise,
      output dst_fall,
      output dst_change,
      output dst_sticky_rise
   );
endinterface

// File: rtl/sync_nff_filter.sv
// rtl/sync_nff_filter.sv - multi-channel N-flop level synchroniser with glitch filter and edge pulses
//
// Purpose: brings WIDTH independent asynchronous levels into the dst_clk
//          domain through STAGES flops, optionally requires FILTER_CYCLES
//          consecutive stable cycles before the output level follows, and
//          produces registered-source rise/fall pulses.
//          Each bit is synchronised on its own; multi-bit values still need
//          gray coding or an async FIFO.
// Ports:
//   dst_clk    in  destination clock, the only clock
//   dst_rst_n  in  asynchronous active-low reset, released synchronously upstream
//   bus        sync_nff_filter_if.slave (src_signal, sticky_clr in;
//              dst_signal, dst_rise, dst_fall, dst_change, dst_sticky_rise out)
// Optional feature: define SYNC_STICKY_EN to build the per-channel sticky
//          rise flags; otherwise dst_sticky_rise is 0 and sticky_clr is ignored.

module sync_nff_filter #(
   parameter int               WIDTH         = 1,
   parameter int               STAGES        = 2,
   parameter int               FILTER_CYCLES = 0,
   parameter logic [WIDTH-1:0] RST_VALUE     = {WIDTH{1'b0}}
) (
   input  logic             dst_clk,
   input  logic             dst_rst_n,
   sync_nff_filter_if.slave bus
);

   generate
      if (STAGES < 2) begin : g_bad_stages
         $error("sync_nff_filter: STAGES must be >= 2");
      end
      if (FILTER_CYCLES < 0) begin : g_bad_filter
         $error("sync_nff_filter: FILTER_CYCLES must be >= 0");
      end
   endgenerate

   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] dst_level;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   // Synchroniser chain: stage 0 is the only flop that may go metastable.
   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_stage [STAGES];

   always_ff @(posedge dst_clk or negedge dst_rst_n) begin
      if (!dst_rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            sync_stage[k] <= RST_VALUE;
         end
      end else begin
         sync_stage[0] <= bus.src_signal;
         for (int k = 1; k < STAGES; k++) begin
            sync_stage[k] <= sync_stage[k-1];
         end
      end
   end

   assign sync_q = sync_stage[STAGES-1];

   generate
      if (FILTER_CYCLES == 0) begin : g_no_filter
         assign dst_level = sync_q;
      end else begin : g_filter
         localparam int               CNT_W    = $clog2(FILTER_CYCLES + 1);
         localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

         logic [CNT_W-1:0] cnt [WIDTH];
         logic [WIDTH-1:0] level_q;

         // The counter only runs while the synchronised value disagrees with
         // the output; any agreement restarts it, so separate glitches never
         // add up to a false transition.
         always_ff @(posedge dst_clk or negedge dst_rst_n) begin
            if (!dst_rst_n) begin
               level_q <= RST_VALUE;
               for (int i = 0; i < WIDTH; i++) begin
                  cnt[i] <= '0;
               end
            end else begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (sync_q[i] == level_q[i]) begin
                     cnt[i] <= '0;
                  end else if (cnt[i] == CNT_LAST) begin
                     level_q[i] <= sync_q[i];
                     cnt[i]     <= '0;
                  end else begin
                     cnt[i] <= cnt[i] + 1'b1;
                  end
               end
            end
         end

         assign dst_level = level_q;
      end
   endgenerate

   // prev_q resets to the same value as the level, so reset release never
   // fabricates an edge.
   always_ff @(posedge dst_clk or negedge dst_rst_n) begin
      if (!dst_rst_n) begin
         prev_q <= RST_VALUE;
      end else begin
         prev_q <= dst_level;
      end
   end

   assign rise = dst_level & ~prev_q;
   assign fall = ~dst_level & prev_q;

   assign bus.dst_signal = dst_level;
   assign bus.dst_rise   = rise;
   assign bus.dst_fall   = fall;
   assign bus.dst_change = |(rise | fall);

`ifdef SYNC_STICKY_EN
   logic [WIDTH-1:0] sticky_q;

   // A rise in the same cycle as a clear wins, so no event is lost.
   always_ff @(posedge dst_clk or negedge dst_rst_n) begin
      if (!dst_rst_n) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= (sticky_q & ~bus.sticky_clr) | rise;
      end
   end

   assign bus.dst_sticky_rise = sticky_q;
`else
   logic unused_sticky_clr;

   assign unused_sticky_clr   = ^bus.sticky_clr;
   assign bus.dst_sticky_rise = '0;
`endif

endmodule
